// File: rtl/input_pkg.sv
// Shared constants and types for the input mapper: scan codes, joystick bit
// positions, the coin hold default and the per-player control bundle.
package input_pkg;

   localparam int COIN_CNT_W = 20;
   localparam logic [COIN_CNT_W-1:0] COIN_HOLD_DEFAULT = 20'd960000;

   // Joystick bit positions
   localparam int JOY_RIGHT = 0;
   localparam int JOY_LEFT  = 1;
   localparam int JOY_DOWN  = 2;
   localparam int JOY_UP    = 3;
   localparam int JOY_B1    = 4;
   localparam int JOY_B2    = 5;
   localparam int JOY_B3    = 6;
   localparam int JOY_START = 7;
   localparam int JOY_COIN  = 8;
   localparam int JOY_PAUSE = 9;

   // Player 1 arrows, only recognised with the extended flag
   localparam logic [7:0] SC_P1_UP    = 8'h75;
   localparam logic [7:0] SC_P1_DOWN  = 8'h72;
   localparam logic [7:0] SC_P1_LEFT  = 8'h6B;
   localparam logic [7:0] SC_P1_RIGHT = 8'h74;

   // Player 1 buttons and system keys
   localparam logic [7:0] SC_P1_B1    = 8'h14;
   localparam logic [7:0] SC_P1_B2    = 8'h11;
   localparam logic [7:0] SC_P1_B3    = 8'h29;
   localparam logic [7:0] SC_P1_START = 8'h16;
   localparam logic [7:0] SC_P1_COIN  = 8'h2E;
   localparam logic [7:0] SC_P1_PAUSE = 8'h4D;

   // Player 2 keys
   localparam logic [7:0] SC_P2_UP    = 8'h2D;
   localparam logic [7:0] SC_P2_DOWN  = 8'h2B;
   localparam logic [7:0] SC_P2_LEFT  = 8'h23;
   localparam logic [7:0] SC_P2_RIGHT = 8'h34;
   localparam logic [7:0] SC_P2_B1    = 8'h1C;
   localparam logic [7:0] SC_P2_B2    = 8'h1B;
   localparam logic [7:0] SC_P2_B3    = 8'h15;
   localparam logic [7:0] SC_P2_START = 8'h1E;
   localparam logic [7:0] SC_P2_COIN  = 8'h36;

   // Service keys
   localparam logic [7:0] SC_SERVICE1 = 8'h46;
   localparam logic [7:0] SC_SERVICE2 = 8'h45;

   // One player's worth of controls; buttons ordered {b3,b2,b1}
   typedef struct packed {
      logic       up;
      logic       down;
      logic       left;
      logic       right;
      logic [2:0] buttons;
      logic       start;
      logic       coin;
      logic       pause;
   } ctrl_t;

   // Ownership of an axis when both directions are held
   typedef enum logic [1:0] {
      SOCD_NONE = 2'd0,
      SOCD_NEG  = 2'd1,
      SOCD_POS  = 2'd2
   } socd_state_t;

   // Unpack the low ten joystick bits into the control bundle
   function automatic ctrl_t joy_to_ctrl(input logic [9:0] joy);
      ctrl_t c;
      c.up      = joy[JOY_UP];
      c.down    = joy[JOY_DOWN];
      c.left    = joy[JOY_LEFT];
      c.right   = joy[JOY_RIGHT];
      c.buttons = {joy[JOY_B3], joy[JOY_B2], joy[JOY_B1]};
      c.start   = joy[JOY_START];
      c.coin    = joy[JOY_COIN];
      c.pause   = joy[JOY_PAUSE];
      return c;
   endfunction

endpackage

// File: rtl/socd_axis.sv
// Resolves one axis (a neg/pos direction pair) so opposite directions are
// never reported together: the most recently risen direction wins, and a
// simultaneous rise blanks the axis until one side is released.
module socd_axis
   import input_pkg::*;
(
   input  logic clk_sys,
   input  logic reset_n,
   input  logic in_neg,
   input  logic in_pos,
   output logic out_neg,
   output logic out_pos,
   output logic last_pos
);

   socd_state_t state;
   socd_state_t state_nxt;
   logic        prev_neg;
   logic        prev_pos;
   logic        rise_neg;
   logic        rise_pos;
   logic        res_neg;
   logic        res_pos;

   assign rise_neg = in_neg & ~prev_neg;
   assign rise_pos = in_pos & ~prev_pos;

   // Track which side rose last and derive the resolved pair from it
   always_comb begin
      state_nxt = state;
      res_neg   = in_neg;
      res_pos   = in_pos;
      if (rise_neg && rise_pos) begin
         state_nxt = SOCD_NONE;
      end else if (rise_neg) begin
         state_nxt = SOCD_NEG;
      end else if (rise_pos) begin
         state_nxt = SOCD_POS;
      end
      if (in_neg && in_pos) begin
         res_neg = (state_nxt == SOCD_NEG);
         res_pos = (state_nxt == SOCD_POS);
      end
   end

   // State, edge history and registered outputs
   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         state    <= SOCD_NONE;
         prev_neg <= 1'b0;
         prev_pos <= 1'b0;
         out_neg  <= 1'b0;
         out_pos  <= 1'b0;
      end else begin
         state    <= state_nxt;
         prev_neg <= in_neg;
         prev_pos <= in_pos;
         out_neg  <= res_neg;
         out_pos  <= res_pos;
      end
   end

   assign last_pos = (state == SOCD_POS);

endmodule

// File: rtl/input_mapper.sv
// Maps PS/2 key events and two joysticks onto arcade player controls.
// Pipeline: key state / toggle detect -> raw control register -> outputs,
// with SOCD cleaning on the directions and a fixed-length coin pulse.
module input_mapper
   import input_pkg::*;
#(
   parameter logic [COIN_CNT_W-1:0] COIN_HOLD = COIN_HOLD_DEFAULT
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic [10:0] ps2_key,
   input  logic [10:0] joystick_0,
   input  logic [10:0] joystick_1,
   output logic        p1_up,
   output logic        p1_down,
   output logic        p1_left,
   output logic        p1_right,
   output logic        p1_start,
   output logic        p1_coin,
   output logic        p1_pause,
   output logic [2:0]  p1_buttons,
   output logic        p2_up,
   output logic        p2_down,
   output logic        p2_left,
   output logic        p2_right,
   output logic        p2_start,
   output logic        p2_coin,
   output logic        p2_pause,
   output logic [2:0]  p2_buttons,
   output logic        service1,
   output logic        service2
);

   logic        toggle_q;
   logic        key_event;
   logic        key_pressed;
   logic        key_ext;
   logic [7:0]  key_code;

   ctrl_t       key_p1;
   ctrl_t       key_p2;
   ctrl_t       key_p1_nxt;
   ctrl_t       key_p2_nxt;
   logic [1:0]  svc_key;
   logic [1:0]  svc_nxt;

   ctrl_t       raw_p1;
   ctrl_t       raw_p2;
   ctrl_t       raw_p1_q;
   ctrl_t       raw_p2_q;
   logic [1:0]  svc_q;

   logic [1:0]            coin_raw;
   logic [1:0]            coin_prev;
   logic [COIN_CNT_W-1:0] coin_cnt     [2];
   logic [COIN_CNT_W-1:0] coin_cnt_nxt [2];

   logic [3:0]  socd_last;
   logic        unused_ok;

   assign key_event   = (ps2_key[10] != toggle_q);
   assign key_pressed = ps2_key[9];
   assign key_ext     = ps2_key[8];
   assign key_code    = ps2_key[7:0];

   // Decode a key event into the matching key-state bit; unmapped codes fall through
   always_comb begin
      key_p1_nxt = key_p1;
      key_p2_nxt = key_p2;
      svc_nxt    = svc_key;
      if (key_event) begin
         if (key_ext) begin
            case (key_code)
               SC_P1_UP:    key_p1_nxt.up    = key_pressed;
               SC_P1_DOWN:  key_p1_nxt.down  = key_pressed;
               SC_P1_LEFT:  key_p1_nxt.left  = key_pressed;
               SC_P1_RIGHT: key_p1_nxt.right = key_pressed;
               default: ;
            endcase
         end
         case (key_code)
            SC_P1_B1:    key_p1_nxt.buttons[0] = key_pressed;
            SC_P1_B2:    key_p1_nxt.buttons[1] = key_pressed;
            SC_P1_B3:    key_p1_nxt.buttons[2] = key_pressed;
            SC_P1_START: key_p1_nxt.start      = key_pressed;
            SC_P1_COIN:  key_p1_nxt.coin       = key_pressed;
            SC_P1_PAUSE: key_p1_nxt.pause      = key_pressed;
            SC_P2_UP:    key_p2_nxt.up         = key_pressed;
            SC_P2_DOWN:  key_p2_nxt.down       = key_pressed;
            SC_P2_LEFT:  key_p2_nxt.left       = key_pressed;
            SC_P2_RIGHT: key_p2_nxt.right      = key_pressed;
            SC_P2_B1:    key_p2_nxt.buttons[0] = key_pressed;
            SC_P2_B2:    key_p2_nxt.buttons[1] = key_pressed;
            SC_P2_B3:    key_p2_nxt.buttons[2] = key_pressed;
            SC_P2_START: key_p2_nxt.start      = key_pressed;
            SC_P2_COIN:  key_p2_nxt.coin       = key_pressed;
            SC_SERVICE1: svc_nxt[0]            = key_pressed;
            SC_SERVICE2: svc_nxt[1]            = key_pressed;
            default: ;
         endcase
      end
   end

   // Key-state and toggle history; the toggle tracks the input during reset so no stale event fires
   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         toggle_q <= ps2_key[10];
         key_p1   <= '0;
         key_p2   <= '0;
         svc_key  <= '0;
      end else begin
         toggle_q <= ps2_key[10];
         key_p1   <= key_p1_nxt;
         key_p2   <= key_p2_nxt;
         svc_key  <= svc_nxt;
      end
   end

   // P2 has no pause key, so key_p2.pause never leaves 0 and pause comes from the joystick
   assign raw_p1 = key_p1 | joy_to_ctrl(joystick_0[9:0]);
   assign raw_p2 = key_p2 | joy_to_ctrl(joystick_1[9:0]);

   // Register the merged raw controls
   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         raw_p1_q <= '0;
         raw_p2_q <= '0;
         svc_q    <= '0;
      end else begin
         raw_p1_q <= raw_p1;
         raw_p2_q <= raw_p2;
         svc_q    <= svc_key;
      end
   end

   socd_axis u_p1_vert (
      .clk_sys  (clk_sys),
      .reset_n  (reset_n),
      .in_neg   (raw_p1_q.up),
      .in_pos   (raw_p1_q.down),
      .out_neg  (p1_up),
      .out_pos  (p1_down),
      .last_pos (socd_last[0])
   );

   socd_axis u_p1_horz (
      .clk_sys  (clk_sys),
      .reset_n  (reset_n),
      .in_neg   (raw_p1_q.left),
      .in_pos   (raw_p1_q.right),
      .out_neg  (p1_left),
      .out_pos  (p1_right),
      .last_pos (socd_last[1])
   );

   socd_axis u_p2_vert (
      .clk_sys  (clk_sys),
      .reset_n  (reset_n),
      .in_neg   (raw_p2_q.up),
      .in_pos   (raw_p2_q.down),
      .out_neg  (p2_up),
      .out_pos  (p2_down),
      .last_pos (socd_last[2])
   );

   socd_axis u_p2_horz (
      .clk_sys  (clk_sys),
      .reset_n  (reset_n),
      .in_neg   (raw_p2_q.left),
      .in_pos   (raw_p2_q.right),
      .out_neg  (p2_left),
      .out_pos  (p2_right),
      .last_pos (socd_last[3])
   );

   assign coin_raw = {raw_p2_q.coin, raw_p1_q.coin};

   // Coin hold counters: an edge only loads an idle counter, so holding or re-pressing never stretches a pulse
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         coin_cnt_nxt[p] = coin_cnt[p];
         if (coin_cnt[p] != '0) begin
            coin_cnt_nxt[p] = coin_cnt[p] - COIN_CNT_W'(1);
         end else if (coin_raw[p] && !coin_prev[p]) begin
            coin_cnt_nxt[p] = COIN_HOLD;
         end
      end
   end

   // Coin counters and edge history
   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         coin_prev <= '0;
         for (int p = 0; p < 2; p++) begin
            coin_cnt[p] <= '0;
         end
      end else begin
         coin_prev <= coin_raw;
         for (int p = 0; p < 2; p++) begin
            coin_cnt[p] <= coin_cnt_nxt[p];
         end
      end
   end

   // Registered level outputs and coin pulse flags
   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         p1_buttons <= '0;
         p1_start   <= 1'b0;
         p1_pause   <= 1'b0;
         p1_coin    <= 1'b0;
         p2_buttons <= '0;
         p2_start   <= 1'b0;
         p2_pause   <= 1'b0;
         p2_coin    <= 1'b0;
         service1   <= 1'b0;
         service2   <= 1'b0;
      end else begin
         p1_buttons <= raw_p1_q.buttons;
         p1_start   <= raw_p1_q.start;
         p1_pause   <= raw_p1_q.pause;
         p1_coin    <= (coin_cnt_nxt[0] != '0);
         p2_buttons <= raw_p2_q.buttons;
         p2_start   <= raw_p2_q.start;
         p2_pause   <= raw_p2_q.pause;
         p2_coin    <= (coin_cnt_nxt[1] != '0);
         service1   <= svc_q[0];
         service2   <= svc_q[1];
      end
   end

   // Joystick bit 10 and the axis ownership flags have no consumer here
   assign unused_ok = &{1'b0, joystick_0[10], joystick_1[10], socd_last};

endmodule
